// File: rtl/register_file_pkg.sv
// Shared constants for the integer register file: architectural register
// indices and the memory-map reset values of sp and gp.
package register_file_pkg;

   localparam int unsigned NUM_REGS      = 32;
   localparam int unsigned REG_IDX_WIDTH = 5;

   localparam logic [REG_IDX_WIDTH-1:0] ZERO = 5'd0;
   localparam logic [REG_IDX_WIDTH-1:0] RA   = 5'd1;
   localparam logic [REG_IDX_WIDTH-1:0] SP   = 5'd2;
   localparam logic [REG_IDX_WIDTH-1:0] GP   = 5'd3;

   // Top of the stack region and the middle of the small-data region.
   // The data-memory map uses the same values.
   localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
   localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage : register_file_pkg

// File: rtl/register_file_cell.sv
// One architectural register: a DATA_WIDTH-wide flop with load enable and
// an asynchronous active-low reset to a per-instance RESET_VALUE.
module register_cell #(
   parameter int unsigned             DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   // Load d on enabled edges; reset wins immediately, so an in-flight write
   // on the reset edge is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VALUE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : register_cell

// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file. Two combinational read ports
// (rs1 -> ALU operand A, rs2 -> B-operand mux / store data), one write port
// from the write-back mux. x0 has no storage and always reads zero.
module register_file
   import register_file_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH   = 32,
   parameter int unsigned           ADDR_WIDTH   = 5,
   parameter logic [DATA_WIDTH-1:0] SP_INIT      = SP_INIT_DEFAULT,
   parameter logic [DATA_WIDTH-1:0] GP_INIT      = GP_INIT_DEFAULT,
   parameter bit                    WRITE_BYPASS = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Reg_Write_i,
   input  logic [ADDR_WIDTH-1:0] Write_Register_i,
   input  logic [DATA_WIDTH-1:0] Write_Data_i,
   input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
   input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
   output logic [DATA_WIDTH-1:0] Read_Data_1_o,
   output logic [DATA_WIDTH-1:0] Read_Data_2_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic                  write_valid;
   logic [DEPTH-1:0]      write_en;
   logic [DATA_WIDTH-1:0] reg_q [DEPTH];

   // A write only counts when enabled and not aimed at x0.
   assign write_valid = Reg_Write_i && (Write_Register_i != ZERO);

   // One-hot write-enable decode of rd.
   always_comb begin
      write_en = '0;
      if (write_valid) begin
         write_en[Write_Register_i] = 1'b1;
      end
   end

   assign reg_q[0] = '0;

   genvar i;
   generate
      for (i = 1; i < DEPTH; i++) begin : g_reg
         localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(i);
         localparam logic [DATA_WIDTH-1:0] RV  = (IDX == SP) ? SP_INIT :
                                                 (IDX == GP) ? GP_INIT : '0;
         register_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RV)
         ) u_cell (
            .clk   (clk),
            .rst_n (reset),
            .en    (write_en[i]),
            .d     (Write_Data_i),
            .q     (reg_q[i])
         );
      end
   endgenerate

   // Read muxes with optional same-cycle forwarding of the write data.
   // Forwarding is suppressed while reset is held so reads show reset values,
   // and never applies to x0 because write_valid already excludes it.
   always_comb begin
      Read_Data_1_o = reg_q[Read_Register_1_i];
      Read_Data_2_o = reg_q[Read_Register_2_i];
      if (WRITE_BYPASS && reset && write_valid) begin
         if (Write_Register_i == Read_Register_1_i) begin
            Read_Data_1_o = Write_Data_i;
         end
         if (Write_Register_i == Read_Register_2_i) begin
            Read_Data_2_o = Write_Data_i;
         end
      end
   end

endmodule : register_file

// File: tb/tb_register_file.sv
// Bench for register_file: one instance with write bypass, one without,
// driven from the same inputs.
module tb_register_file;
   import register_file_pkg::*;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

   int n_checks;
   int n_errors;
   logic [31:0] exp_q[$];

   // Reference: architectural register contents
   logic [31:0] model_regs [32];

   register_file #(.WRITE_BYPASS(1'b1)) dut (
      .clk               (clk),
      .reset             (reset),
      .Reg_Write_i       (we),
      .Write_Register_i  (wa),
      .Write_Data_i      (wd),
      .Read_Register_1_i (ra1),
      .Read_Register_2_i (ra2),
      .Read_Data_1_o     (rd1_b),
      .Read_Data_2_o     (rd2_b)
   );

   register_file #(.WRITE_BYPASS(1'b0)) dut_nb (
      .clk               (clk),
      .reset             (reset),
      .Reg_Write_i       (we),
      .Write_Register_i  (wa),
      .Write_Data_i      (wd),
      .Read_Register_1_i (ra1),
      .Read_Register_2_i (ra2),
      .Read_Data_1_o     (rd1_n),
      .Read_Data_2_o     (rd2_n)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] b1, b2, n1, n2;
   } vec_t;

   vec_t vecs [10];

   task automatic model_reset();
      for (int k = 0; k < 32; k++) model_regs[k] = 32'h0;
      model_regs[2] = 32'h7FFF_EFFC;
      model_regs[3] = 32'h1000_8000;
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] idx, input bit bypass);
      if (idx == 5'd0) return 32'h0;
      if (bypass && reset && we && wa != 5'd0 && wa == idx) return wd;
      return model_regs[idx];
   endfunction

   // Advance one edge; the model commits the write the DUT sees on that edge.
   task automatic step();
      @(posedge clk);
      if (reset && we && wa != 5'd0) model_regs[wa] = wd;
      #1;
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [4:0] r1, input logic [4:0] r2);
      we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
   endtask

   // Scoreboard: queue the four expected port values, then retire against actuals.
   task automatic check_ports(input string name, input logic [31:0] e_b1, input logic [31:0] e_b2,
                              input logic [31:0] e_n1, input logic [31:0] e_n2);
      logic [31:0] act [4];
      logic [31:0] e;
      act[0] = rd1_b; act[1] = rd2_b; act[2] = rd1_n; act[3] = rd2_n;
      exp_q.push_back(e_b1); exp_q.push_back(e_b2);
      exp_q.push_back(e_n1); exp_q.push_back(e_n2);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (act[k] !== e) begin
            n_errors++;
            $display("FAIL %s port%0d: got %h expected %h", name, k, act[k], e);
         end
      end
   endtask

   task automatic check_model(input string name);
      check_ports(name, model_read(ra1, 1'b1), model_read(ra2, 1'b1),
                  model_read(ra1, 1'b0), model_read(ra2, 1'b0));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd3);

      // Reset pulse between edges, checked before any clock edge
      #2 reset = 1'b0;
      model_reset();
      #1 check_ports("reset_sp_gp", 32'h7FFF_EFFC, 32'h1000_8000, 32'h7FFF_EFFC, 32'h1000_8000);
      ra1 = 5'd5; ra2 = 5'd0;
      #1 check_ports("reset_x5_x0", 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk) reset = 1'b1;

      // Directed vectors: expected values before the edge, for bypass / no-bypass
      vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
      vecs[1] = '{1'b1, 5'd6, 32'h0000_0010, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF, 32'h0};
      vecs[2] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF, 32'h10};
      vecs[3] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[4] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[5] = '{1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0};
      vecs[6] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      vecs[7] = '{1'b0, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[8] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd2, 32'h0, 32'h7FFF_EFFC, 32'h0, 32'h7FFF_EFFC};
      vecs[9] = '{1'b1, 5'd3, 32'hCAFE_0001, 5'd3, 5'd3, 32'hCAFE_0001, 32'hCAFE_0001, 32'h1000_8000, 32'h1000_8000};

      @(posedge clk) #1;
      for (int v = 0; v < 10; v++) begin
         drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
         @(negedge clk);
         check_ports($sformatf("vec%0d", v), vecs[v].b1, vecs[v].b2, vecs[v].n1, vecs[v].n2);
         if (v == 2) begin
            n_checks++;
            if (rd1_b + rd2_b !== 32'hDEAD_BEFF) begin
               n_errors++;
               $display("FAIL alu_add: got %h expected %h", rd1_b + rd2_b, 32'hDEAD_BEFF);
            end
         end
         step();
      end

      // Reset asserted between edges while x10 is being written every cycle
      drive(1'b1, 5'd10, 32'h55, 5'd10, 5'd2);
      step();
      step();
      #2 reset = 1'b0;
      model_reset();
      #1 check_ports("rst_mid_x10", 32'h0, 32'h7FFF_EFFC, 32'h0, 32'h7FFF_EFFC);
      step();
      #1 check_ports("rst_hold_edge", 32'h0, 32'h7FFF_EFFC, 32'h0, 32'h7FFF_EFFC);
      we = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk) #1;
      drive(1'b1, 5'd10, 32'h66, 5'd10, 5'd10);
      step();
      we = 1'b0;
      @(negedge clk) check_ports("post_rst_x10", 32'h66, 32'h66, 32'h66, 32'h66);
      step();

      // Randomized traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) ra1 = wa;
         if ($urandom_range(0, 3) == 0) ra2 = wa;
         @(negedge clk);
         check_model($sformatf("rand%0d", c));
         step();
      end

      // Read back every register after the random phase
      we = 1'b0;
      for (int r = 0; r < 32; r++) begin
         ra1 = 5'(r);
         ra2 = 5'(31 - r);
         #1 check_model($sformatf("sweep%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_register_file
